// File: rtl/binary_adder_32_bit_serial_if.sv
// ============================================================================
// binary_adder_32_bit_serial_if : start/done operand and result bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface binary_adder_32_bit_serial_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             c0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c32;

   modport master (
      output start, x, y, c0,
      input  busy, done, s, c32
   );

   modport slave (
      input  start, x, y, c0,
      output busy, done, s, c32
   );
endinterface

`default_nettype wire

// File: rtl/binary_adder_32_bit_serial.sv
// ============================================================================
// binary_adder_32_bit_serial : bit-serial {c32, s} = x + y + c0, one bit/clock
// Rev 1.0
// ============================================================================
`default_nettype none

module binary_adder_32_bit_serial #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  wire                               clk,
   input  wire                               rst_n,
   binary_adder_32_bit_serial_if.slave       bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  xr_q, xr_d;
   logic [WIDTH-1:0]  yr_q, yr_d;
   logic [WIDTH-1:0]  s_q, s_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cy_q, cy_d;
   logic              c32_q, c32_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // The single full-adder cell shared across all bit positions.
   logic              sum_bit;
   logic              carry_out;

   always_comb begin
      sum_bit   = xr_q[0] ^ yr_q[0] ^ cy_q;
      carry_out = (xr_q[0] & yr_q[0]) | (xr_q[0] & cy_q) | (yr_q[0] & cy_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         xr_q    <= '0;
         yr_q    <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         c32_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         c32_q   <= c32_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      c32_d   = c32_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new start exactly like IDLE for back-to-back use.
            if (bus.start) begin
               xr_d    = bus.x;
               yr_d    = bus.y;
               cy_d    = bus.c0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            s_d   = {sum_bit, s_q[WIDTH-1:1]};
            cy_d  = carry_out;
            xr_d  = {1'b0, xr_q[WIDTH-1:1]};
            yr_d  = {1'b0, yr_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               c32_d   = carry_out;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.s    = s_q;
   assign bus.c32  = c32_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_adder_32_bit_serial.sv
// ============================================================================
// tb_binary_adder_32_bit_serial : directed + random checks against x+y+c0
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_binary_adder_32_bit_serial;
   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   binary_adder_32_bit_serial_if #(.WIDTH(W)) bus ();

   binary_adder_32_bit_serial #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start for exactly one rising edge; returns 1ns after that edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      @(negedge clk);
      bus.x     = a;
      bus.y     = b;
      bus.c0    = ci;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Sample on falling edges until done; counts cycles busy was high.
   task automatic wait_done(input string tag, output int busy_cycles);
      bit seen;
      busy_cycles = 0;
      seen        = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
         else if (bus.busy === 1'b1) busy_cycles++;
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic run_and_check(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic ci);
      logic [W:0] ref_sum;
      int         bc;
      ref_sum = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      start_op(a, b, ci);
      wait_done(tag, bc);
      check({tag, "_busy_len"}, 64'(bc), 64'd32);
      check({tag, "_s"}, 64'(bus.s), 64'(ref_sum[W-1:0]));
      check({tag, "_c32"}, 64'(bus.c32), 64'(ref_sum[W]));
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check({tag, "_s_hold"}, 64'(bus.s), 64'(ref_sum[W-1:0]));
   endtask

   initial begin
      logic [W:0]   ref_sum;
      logic [W-1:0] rx, ry, rd;
      logic         rb;
      int           bc;
      int           pulses;

      total     = 0;
      bad       = 0;
      rst_n     = 1'b1;
      bus.start = 1'b0;
      bus.x     = '0;
      bus.y     = '0;
      bus.c0    = 1'b0;

      #3 rst_n = 1'b0;
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_s",    64'(bus.s),    64'd0);
      check("rst_c32",  64'(bus.c32),  64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);

      run_and_check("aaaa", 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0);
      check("aaaa_const_s", 64'(bus.s), 64'h55555554);
      run_and_check("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1);
      check("ripple_const_c32", 64'(bus.c32), 64'd1);

      // Inputs change after acceptance and a second start arrives mid-RUN.
      start_op(32'h12345678, 32'h0000000F, 1'b0);
      @(negedge clk);
      bus.x = '0;
      bus.y = '0;
      repeat (8) @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done("ignore", bc);
      check("ignore_s",   64'(bus.s),   64'h12345687);
      check("ignore_c32", 64'(bus.c32), 64'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
      end
      check("ignore_extra_done", 64'(pulses), 64'd0);
      check("ignore_idle_busy", 64'(bus.busy), 64'd0);

      // Back-to-back: start driven during the done cycle.
      start_op(32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0);
      wait_done("b2b_first", bc);
      check("b2b_first_s", 64'(bus.s), 64'h55555554);
      bus.x     = 32'd5;
      bus.y     = 32'd7;
      bus.c0    = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check("b2b_busy_after_accept", 64'(bus.busy), 64'd1);
      wait_done("b2b_second", bc);
      check("b2b_second_len", 64'(bc), 64'd32);
      check("b2b_second_s",   64'(bus.s),   64'd13);
      check("b2b_second_c32", 64'(bus.c32), 64'd0);

      // Asynchronous reset mid-operation.
      start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_s",    64'(bus.s),    64'd0);
      check("arst_c32",  64'(bus.c32),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      end
      check("arst_stays_idle", 64'(pulses), 64'd0);
      run_and_check("post_rst", 32'd1, 32'd1, 1'b0);

      // Recombination with a subtractor result: (x - y - b0) + y + b0 == x.
      for (int n = 0; n < 100; n++) begin
         rx = $urandom;
         ry = $urandom;
         rb = 1'($urandom_range(0, 1));
         rd = rx - ry - W'(rb);
         ref_sum = {1'b0, rd} + {1'b0, ry} + (W+1)'(rb);
         start_op(rd, ry, rb);
         wait_done("recomb", bc);
         check("recomb_s",   64'(bus.s),   64'(rx));
         check("recomb_c32", 64'(bus.c32), 64'(ref_sum[W]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
